bullet_pool_ctrl: RTL and testbench

//   Shared bullet-slot controller for the tank game. Arbitrates shoot requests from N_REQ

---
 rtl/bullet_pool_ctrl.sv | 179 +++++++++++++++++
 tb/tb_bullet_pool_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_pool_ctrl.sv
// Shared bullet-slot pool for the tank game: round-robin shoot arbitration, spawn next to
// the shooter, one-cell-per-tick movement, and release on field exit or hit.
module bullet_pool_ctrl #(
  parameter int N_REQ  = 4,
  parameter int N_SLOT = 4,
  parameter int OWN_W  = 2,
  parameter int XY_W   = 5,
  parameter int X_MAX  = 15,
  parameter int Y_MAX  = 19
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    game_en,
  input  logic                    tick,
  input  logic [N_REQ-1:0]        sht_req,
  input  logic [N_REQ*XY_W-1:0]   tank_x,
  input  logic [N_REQ*XY_W-1:0]   tank_y,
  input  logic [N_REQ*2-1:0]      tank_dir,
  input  logic [N_SLOT-1:0]       hit_clr,
  output logic [N_SLOT*XY_W-1:0]  bul_x,
  output logic [N_SLOT*XY_W-1:0]  bul_y,
  output logic [N_SLOT*2-1:0]     bul_dir,
  output logic [N_SLOT-1:0]       bul_active,
  output logic [N_SLOT*OWN_W-1:0] bul_owner,
  output logic [N_REQ-1:0]        req_busy,
  output logic [N_REQ-1:0]        sht_gnt,
  output logic                    sht_rej
);
  localparam int W = XY_W + 1;

  // Neighbouring cell, one bit wider than a coordinate so 0-1 and MAX+1 stay distinguishable.
  function automatic logic [2*W-1:0] step_cell(input logic [XY_W-1:0] x,
                                               input logic [XY_W-1:0] y,
                                               input logic [1:0]      dir);
    logic [W-1:0] nx;
    logic [W-1:0] ny;
    nx = {1'b0, x};
    ny = {1'b0, y};
    case (dir)
      2'b00:   ny = ny + W'(1);
      2'b01:   ny = ny - W'(1);
      2'b10:   nx = nx + W'(1);
      2'b11:   nx = nx - W'(1);
      default: nx = nx;
    endcase
    return {nx, ny};
  endfunction

  function automatic logic on_field(input logic [2*W-1:0] c);
    logic [W-1:0] cx;
    logic [W-1:0] cy;
    cx = c[2*W-1:W];
    cy = c[W-1:0];
    return (cx >= W'(1)) && (cx <= W'(X_MAX)) && (cy >= W'(1)) && (cy <= W'(Y_MAX));
  endfunction

  logic [OWN_W-1:0]        ptr_r;
  logic [N_SLOT*XY_W-1:0]  x_s;
  logic [N_SLOT*XY_W-1:0]  y_s;
  logic [N_SLOT*2-1:0]     dir_s;
  logic [N_SLOT-1:0]       act_s;
  logic [N_SLOT*OWN_W-1:0] own_s;
  logic [N_REQ-1:0]        busy_s;
  logic [N_REQ-1:0]        gnt_s;
  logic [N_REQ-1:0]        elig_s;
  logic                    rej_s;
  logic [OWN_W-1:0]        ptr_s;
  logic                    win_vld_s;
  int                      win_s;
  logic                    slot_vld_s;
  int                      slot_s;
  logic [2*W-1:0]          cell_s;
  logic [2*W-1:0]          spawn_s;

  // Next slot state: free/step live bullets, then arbitrate one spawn into a slot idle last cycle.
  always_comb begin
    x_s        = bul_x;
    y_s        = bul_y;
    dir_s      = bul_dir;
    act_s      = bul_active;
    own_s      = bul_owner;
    busy_s     = '0;
    gnt_s      = '0;
    rej_s      = 1'b0;
    ptr_s      = ptr_r;
    win_vld_s  = 1'b0;
    win_s      = 0;
    slot_vld_s = 1'b0;
    slot_s     = 0;
    cell_s     = '0;
    elig_s     = sht_req & ~req_busy & {N_REQ{game_en}};

    for (int s = 0; s < N_SLOT; s++) begin
      cell_s = step_cell(bul_x[s*XY_W +: XY_W], bul_y[s*XY_W +: XY_W], bul_dir[s*2 +: 2]);
      if (bul_active[s] && (hit_clr[s] || (tick && game_en && !on_field(cell_s)))) begin
        act_s[s]               = 1'b0;
        x_s[s*XY_W +: XY_W]    = '0;
        y_s[s*XY_W +: XY_W]    = '0;
        dir_s[s*2 +: 2]        = 2'b00;
        own_s[s*OWN_W +: OWN_W] = '0;
      end else if (bul_active[s] && tick && game_en) begin
        x_s[s*XY_W +: XY_W] = cell_s[2*W-2:W];
        y_s[s*XY_W +: XY_W] = cell_s[W-2:0];
      end else begin
        act_s[s] = act_s[s];
      end
    end

    for (int k = 0; k < N_REQ; k++) begin
      if (!win_vld_s && elig_s[(int'(ptr_r) + k) % N_REQ]) begin
        win_vld_s = 1'b1;
        win_s     = (int'(ptr_r) + k) % N_REQ;
      end else begin
        win_vld_s = win_vld_s;
      end
    end

    for (int s = 0; s < N_SLOT; s++) begin
      if (!slot_vld_s && !bul_active[s]) begin
        slot_vld_s = 1'b1;
        slot_s     = s;
      end else begin
        slot_vld_s = slot_vld_s;
      end
    end

    spawn_s = step_cell(tank_x[win_s*XY_W +: XY_W], tank_y[win_s*XY_W +: XY_W],
                        tank_dir[win_s*2 +: 2]);
    if (win_vld_s && !on_field(spawn_s)) begin
      rej_s = 1'b1;
      ptr_s = OWN_W'((win_s + 1) % N_REQ);
    end else if (win_vld_s && slot_vld_s) begin
      act_s[slot_s]                = 1'b1;
      x_s[slot_s*XY_W +: XY_W]     = spawn_s[2*W-2:W];
      y_s[slot_s*XY_W +: XY_W]     = spawn_s[W-2:0];
      dir_s[slot_s*2 +: 2]         = tank_dir[win_s*2 +: 2];
      own_s[slot_s*OWN_W +: OWN_W] = OWN_W'(win_s);
      gnt_s[win_s]                 = 1'b1;
      ptr_s                        = OWN_W'((win_s + 1) % N_REQ);
    end else begin
      ptr_s = ptr_r;
    end

    for (int i = 0; i < N_REQ; i++) begin
      for (int s = 0; s < N_SLOT; s++) begin
        if (act_s[s] && (own_s[s*OWN_W +: OWN_W] == OWN_W'(i))) begin
          busy_s[i] = 1'b1;
        end else begin
          busy_s[i] = busy_s[i];
        end
      end
    end
  end

  // Slot, pointer and feedback registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bul_x      <= '0;
      bul_y      <= '0;
      bul_dir    <= '0;
      bul_active <= '0;
      bul_owner  <= '0;
      req_busy   <= '0;
      sht_gnt    <= '0;
      sht_rej    <= 1'b0;
      ptr_r      <= '0;
    end else begin
      bul_x      <= x_s;
      bul_y      <= y_s;
      bul_dir    <= dir_s;
      bul_active <= act_s;
      bul_owner  <= own_s;
      req_busy   <= busy_s;
      sht_gnt    <= gnt_s;
      sht_rej    <= rej_s;
      ptr_r      <= ptr_s;
    end
  end
endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// Scoreboard bench for bullet_pool_ctrl: a 4-slot and a 2-slot instance share stimulus and
// are compared each cycle against a slot-list reference model.
module tb_bullet_pool_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        game_en = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  sht_req = 4'd0;
  logic [3:0]  hit_clr = 4'd0;
  logic [19:0] tank_x = 20'd0;
  logic [19:0] tank_y = 20'd0;
  logic [7:0]  tank_dir = 8'd0;

  logic [19:0] b4_x, b4_y;
  logic [7:0]  b4_dir, b4_own;
  logic [3:0]  b4_act, b4_busy, b4_gnt;
  logic        b4_rej;
  logic [9:0]  b2_x, b2_y;
  logic [3:0]  b2_dir, b2_own;
  logic [1:0]  b2_act;
  logic [3:0]  b2_busy, b2_gnt;
  logic        b2_rej;

  int vectors = 0;
  int miscompares = 0;

  bullet_pool_ctrl #(.N_SLOT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .game_en(game_en), .tick(tick), .sht_req(sht_req),
    .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir), .hit_clr(hit_clr),
    .bul_x(b4_x), .bul_y(b4_y), .bul_dir(b4_dir), .bul_active(b4_act), .bul_owner(b4_own),
    .req_busy(b4_busy), .sht_gnt(b4_gnt), .sht_rej(b4_rej));

  bullet_pool_ctrl #(.N_SLOT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .game_en(game_en), .tick(tick), .sht_req(sht_req),
    .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir), .hit_clr(hit_clr[1:0]),
    .bul_x(b2_x), .bul_y(b2_y), .bul_dir(b2_dir), .bul_active(b2_act), .bul_owner(b2_own),
    .req_busy(b2_busy), .sht_gnt(b2_gnt), .sht_rej(b2_rej));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]      act;
    logic [3:0][7:0] x;
    logic [3:0][7:0] y;
    logic [3:0][1:0] d;
    logic [3:0][1:0] o;
    logic [1:0]      ptr;
    logic [3:0]      gnt;
    logic            rej;
  } mdl_t;

  mdl_t m4 = '0;
  mdl_t m2 = '0;
  mdl_t q4[$];
  mdl_t q2[$];
  mdl_t e4, e2;
  logic [19:0] st_x = 20'd0;
  logic [19:0] st_y = 20'd0;
  logic [7:0]  st_d = 8'd0;

  wire [68:0] act4 = {b4_x, b4_y, b4_dir, b4_act, b4_own, b4_busy, b4_gnt, b4_rej};
  wire [68:0] act2 = {10'd0, b2_x, 10'd0, b2_y, 4'd0, b2_dir, 2'd0, b2_act, 4'd0, b2_own,
                      b2_busy, b2_gnt, b2_rej};

  function automatic int ddx(input logic [1:0] d);
    return (d == 2'b10) ? 1 : (d == 2'b11) ? -1 : 0;
  endfunction

  function automatic int ddy(input logic [1:0] d);
    return (d == 2'b00) ? 1 : (d == 2'b01) ? -1 : 0;
  endfunction

  function automatic bit inside_field(input int x, input int y);
    return (x >= 1) && (x <= 15) && (y >= 1) && (y <= 19);
  endfunction

  // Reference: a list of slots, each live bullet stored as (x, y, dir, owner).
  function automatic mdl_t model_next(input mdl_t m, input int ns, input logic en,
                                      input logic tk, input logic [3:0] req,
                                      input logic [3:0] hc, input logic [19:0] tx,
                                      input logic [19:0] ty, input logic [7:0] td);
    mdl_t n;
    int nx, ny, win, slot, t;
    bit [3:0] busy;
    n = m;
    n.gnt = 4'd0;
    n.rej = 1'b0;
    busy = 4'd0;
    for (int s = 0; s < ns; s++) if (m.act[s]) busy[m.o[s]] = 1'b1;
    for (int s = 0; s < ns; s++) begin
      if (m.act[s]) begin
        nx = int'(m.x[s]) + ddx(m.d[s]);
        ny = int'(m.y[s]) + ddy(m.d[s]);
        if (hc[s] || (en && tk && !inside_field(nx, ny))) begin
          n.act[s] = 1'b0; n.x[s] = 8'd0; n.y[s] = 8'd0; n.d[s] = 2'd0; n.o[s] = 2'd0;
        end else if (en && tk) begin
          n.x[s] = 8'(nx); n.y[s] = 8'(ny);
        end
      end
    end
    win = -1;
    if (en) begin
      for (int k = 0; k < 4; k++) begin
        t = (int'(m.ptr) + k) % 4;
        if (win < 0 && req[t] && !busy[t]) win = t;
      end
    end
    if (win >= 0) begin
      nx = int'(tx[win*5 +: 5]) + ddx(td[win*2 +: 2]);
      ny = int'(ty[win*5 +: 5]) + ddy(td[win*2 +: 2]);
      if (!inside_field(nx, ny)) begin
        n.rej = 1'b1;
        n.ptr = 2'((win + 1) % 4);
      end else begin
        slot = -1;
        for (int s = 0; s < ns; s++) if (slot < 0 && !m.act[s]) slot = s;
        if (slot >= 0) begin
          n.act[slot] = 1'b1; n.x[slot] = 8'(nx); n.y[slot] = 8'(ny);
          n.d[slot] = td[win*2 +: 2]; n.o[slot] = 2'(win);
          n.gnt[win] = 1'b1;
          n.ptr = 2'((win + 1) % 4);
        end
      end
    end
    return n;
  endfunction

  function automatic logic [68:0] expect_vec(input mdl_t e, input int ns);
    logic [19:0] ex, ey;
    logic [7:0]  ed, eo;
    logic [3:0]  ea, eb;
    ex = '0; ey = '0; ed = '0; eo = '0; ea = '0; eb = '0;
    for (int s = 0; s < ns; s++) begin
      ex[s*5 +: 5] = e.x[s][4:0];
      ey[s*5 +: 5] = e.y[s][4:0];
      ed[s*2 +: 2] = e.d[s];
      eo[s*2 +: 2] = e.o[s];
      ea[s]        = e.act[s];
      if (e.act[s]) eb[e.o[s]] = 1'b1;
    end
    return {ex, ey, ed, ea, eo, eb, e.gnt, e.rej};
  endfunction

  task automatic vcheck(input string nm, input logic [68:0] got, input logic [68:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  task automatic dchk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  task automatic set_tank(input int i, input int x, input int y, input int d);
    st_x[i*5 +: 5] = 5'(x);
    st_y[i*5 +: 5] = 5'(y);
    st_d[i*2 +: 2] = 2'(d);
  endtask

  task automatic cycle(input logic en, input logic tk, input logic [3:0] req,
                       input logic [3:0] hc);
    @(negedge clk);
    game_en = en; tick = tk; sht_req = req; hit_clr = hc;
    tank_x = st_x; tank_y = st_y; tank_dir = st_d;
    m4 = model_next(m4, 4, en, tk, req, hc, st_x, st_y, st_d);
    m2 = model_next(m2, 2, en, tk, req, hc, st_x, st_y, st_d);
    q4.push_back(m4);
    q2.push_back(m2);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; game_en = 1'b0; tick = 1'b0; sht_req = 4'd0; hit_clr = 4'd0;
    #1;
    vcheck("reset_dut4", act4, 69'd0);
    vcheck("reset_dut2", act2, 69'd0);
    m4 = '0;
    m2 = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare each DUT against the oldest expected state once it has been clocked in.
  always @(posedge clk) begin
    #1;
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      vcheck("scoreboard_dut4", act4, expect_vec(e4, 4));
    end
    if (q2.size() > 0) begin
      e2 = q2.pop_front();
      vcheck("scoreboard_dut2", act2, expect_vec(e2, 2));
    end
  end

  initial begin
    #3;
    do_reset();
    set_tank(0, 5, 5, 0);
    set_tank(1, 10, 7, 2);
    set_tank(2, 8, 10, 1);
    set_tank(3, 3, 3, 3);

    cycle(1'b1, 1'b0, 4'b0001, 4'b0000);
    settle();
    dchk("spawn_gnt", 32'(b4_gnt), 32'd1);
    dchk("spawn_xy", {22'd0, b4_x[4:0], b4_y[4:0]}, {22'd0, 5'd5, 5'd6});
    dchk("spawn_busy", 32'(b4_busy), 32'd1);

    repeat (13) cycle(1'b1, 1'b1, 4'b0000, 4'b0000);
    settle();
    dchk("top_row_y", 32'(b4_y[4:0]), 32'd19);
    cycle(1'b1, 1'b1, 4'b0000, 4'b0000);
    settle();
    dchk("exit_free", {b4_act, b4_busy, 4'd0, 20'd0}, 32'd0);
    dchk("exit_xy", 32'({b4_x[4:0], b4_y[4:0]}), 32'd0);

    repeat (4) cycle(1'b1, 1'b0, 4'b1111, 4'b0000);
    settle();
    dchk("fill_act4", 32'(b4_act), 32'hf);
    dchk("fill_own4", 32'(b4_own), 32'(8'b00_11_10_01));
    dchk("fill_own2", 32'(b2_own), 32'(4'b10_01));
    cycle(1'b1, 1'b0, 4'b1111, 4'b0001);
    settle();
    dchk("freed_no_reuse", 32'(b2_gnt), 32'd0);
    cycle(1'b1, 1'b0, 4'b1111, 4'b0000);
    settle();
    dchk("waiter_gnt", 32'(b2_gnt), 32'h8);
    cycle(1'b1, 1'b0, 4'b0000, 4'b1111);

    set_tank(1, 15, 7, 2);
    cycle(1'b1, 1'b0, 4'b0010, 4'b0000);
    settle();
    dchk("edge_rej", {31'd0, b4_rej}, 32'd1);
    dchk("edge_no_gnt", 32'({b4_gnt, b4_busy[1]}), 32'd0);

    cycle(1'b1, 1'b0, 4'b0001, 4'b0000);
    cycle(1'b1, 1'b1, 4'b0000, 4'b0001);
    settle();
    dchk("hit_beats_tick", 32'({b4_act[0], b4_y[4:0]}), 32'd0);
    cycle(1'b1, 1'b0, 4'b0001, 4'b0000);
    cycle(1'b0, 1'b1, 4'b0000, 4'b0000);
    settle();
    dchk("frozen_y", 32'({b4_act[0], b4_y[4:0]}), 32'({1'b1, 5'd6}));
    cycle(1'b1, 1'b0, 4'b0000, 4'b1111);

    for (int i = 0; i < 1500; i++) begin
      for (int t = 0; t < 4; t++) begin
        if ($urandom_range(0, 9) == 0)
          set_tank(t, $urandom_range(1, 15), $urandom_range(1, 19), $urandom_range(0, 3));
      end
      if (i == 700) begin
        settle();
        do_reset();
      end
      cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) == 0), 4'($urandom),
            4'($urandom & $urandom & $urandom & $urandom));
    end
    settle();
    dchk("queue_drained", 32'(q4.size() + q2.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
